// File: rtl/key_event_decoder.sv
// key_event_decoder: turns debounced key strobes into short, double, long and auto-repeat event pulses
module key_event_decoder #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int LONG_MS   = 1000,
  parameter int DOUBLE_MS = 300,
  parameter int REPEAT_MS = 200
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic keyvalue,
  input  logic keyflag,
  output logic short_press,
  output logic double_press,
  output logic long_press,
  output logic repeat_press
);
  localparam int CPM    = CLK_FREQ / 1000;
  localparam int MAX_AB = LONG_MS > DOUBLE_MS ? LONG_MS : DOUBLE_MS;
  localparam int MAX_MS = MAX_AB > REPEAT_MS ? MAX_AB : REPEAT_MS;
  localparam int PW     = CPM > 1 ? $clog2(CPM) : 1;
  localparam int MW     = MAX_MS > 1 ? $clog2(MAX_MS) : 1;
  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG} state_t;
  state_t        state_q, state_d;
  logic [PW-1:0] presc_q;
  logic [MW-1:0] ms_q;
  logic          short_d, double_d, long_d, rep_d;
  logic          press, rel, ms_tick, hit_long, hit_dbl, hit_rep, restart;
  assign press    = keyflag & ~keyvalue;
  assign rel      = keyflag & keyvalue;
  assign ms_tick  = presc_q == PW'(CPM - 1);
  assign hit_long = ms_tick && ms_q == MW'(LONG_MS - 1);
  assign hit_dbl  = ms_tick && ms_q == MW'(DOUBLE_MS - 1);
  assign hit_rep  = ms_tick && ms_q == MW'(REPEAT_MS - 1);
  // a strobe always takes priority over a threshold tick in the same cycle
  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    rep_d    = 1'b0;
    case (state_q)
      IDLE:   state_d = press ? PRESS1 : IDLE;
      PRESS1: begin
        state_d = rel ? WAIT2 : hit_long ? LONG : PRESS1;
        long_d  = !rel && hit_long;
      end
      WAIT2:  begin
        state_d = press ? PRESS2 : hit_dbl ? IDLE : WAIT2;
        short_d = !press && hit_dbl;
      end
      PRESS2: begin
        state_d  = rel ? IDLE : PRESS2;
        double_d = rel;
      end
      LONG:   begin
        state_d = rel ? IDLE : LONG;
        rep_d   = !rel && hit_rep;
      end
      default: state_d = IDLE;
    endcase
  end
  assign restart = (state_d != state_q) || rep_d;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      ms_q         <= '0;
      short_press  <= 1'b0;
      double_press <= 1'b0;
      long_press   <= 1'b0;
      repeat_press <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= (restart || ms_tick) ? '0 : presc_q + PW'(1);
      ms_q         <= restart ? '0 : ms_q + MW'(ms_tick);
      short_press  <= short_d;
      double_press <= double_d;
      long_press   <= long_d;
      repeat_press <= rep_d;
    end
  end
endmodule

// File: tb/tb_key_event_decoder.sv
// tb_key_event_decoder: directed gestures with a queued scoreboard of expected pulses and their cycles
module tb_key_event_decoder;
  logic clk = 0, rst = 1, keyvalue = 1, keyflag = 0;
  logic short_press, double_press, long_press, repeat_press;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {logic [3:0] k; int c;} exp_t;
  exp_t q[$];
  localparam logic [3:0] SHORT = 4'b1000, DBL = 4'b0100, LNG = 4'b0010, REP = 4'b0001;

  key_event_decoder #(.CLK_FREQ(10_000), .LONG_MS(20), .DOUBLE_MS(5), .REPEAT_MS(4)) dut (
    .sys_clk(clk), .sys_rst(rst), .keyvalue(keyvalue), .keyflag(keyflag),
    .short_press(short_press), .double_press(double_press),
    .long_press(long_press), .repeat_press(repeat_press)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: every asserted output must match the head of the queue in kind and cycle
  always @(negedge clk) begin
    logic [3:0] o;
    exp_t e;
    o = {short_press, double_press, long_press, repeat_press};
    if (o !== 4'b0000 && o !== 4'bxxxx) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got %b at cycle %0d, expected none", o, cyc);
      end else begin
        e = q.pop_front();
        if (o !== e.k || cyc != e.c) begin
          errors++;
          $display("FAIL pulse: got %b at cycle %0d, expected %b at cycle %0d", o, cyc, e.k, e.c);
        end
      end
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic strobe(input logic lvl);
    keyvalue = lvl;
    keyflag  = 1;
    @(negedge clk);
    keyflag  = 0;
  endtask

  task automatic expect_pulse(input logic [3:0] k, input int c);
    q.push_back('{k, c});
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected pulses missing, required 0", name, q.size());
    end
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    checks++;
    if ({short_press, double_press, long_press, repeat_press} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 0000",
               {short_press, double_press, long_press, repeat_press});
    end
    rst = 0;
    strobe(1);
    wait_to(cyc + 500);
    check_drained("reset_quiet");
    // single click
    t = cyc;
    strobe(0);
    wait_to(t + 50);
    strobe(1);
    expect_pulse(SHORT, t + 50 + 51);
    wait_to(t + 400);
    check_drained("short");
    // double click
    t = cyc;
    strobe(0);
    wait_to(t + 30);
    strobe(1);
    wait_to(t + 60);
    strobe(0);
    wait_to(t + 90);
    strobe(1);
    expect_pulse(DBL, t + 91);
    wait_to(t + 400);
    check_drained("double");
    // long hold with auto-repeat
    t = cyc;
    strobe(0);
    expect_pulse(LNG, t + 201);
    expect_pulse(REP, t + 241);
    expect_pulse(REP, t + 281);
    wait_to(t + 300);
    strobe(1);
    wait_to(t + 700);
    check_drained("long_repeat");
    // release exactly on the long threshold tick
    t = cyc;
    strobe(0);
    wait_to(t + 200);
    strobe(1);
    expect_pulse(SHORT, t + 251);
    wait_to(t + 600);
    check_drained("release_on_threshold");
    // reset mid-gesture, then a normal click
    t = cyc;
    strobe(0);
    wait_to(t + 100);
    rst = 1;
    @(negedge clk);
    rst = 0;
    wait_to(t + 150);
    strobe(1);
    wait_to(t + 500);
    check_drained("reset_mid_gesture");
    t = cyc;
    strobe(0);
    wait_to(t + 20);
    strobe(1);
    expect_pulse(SHORT, t + 20 + 51);
    wait_to(t + 400);
    check_drained("after_reset_short");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
